// File: rtl/collatz_engine.sv
// collatz_engine: iterates the Collatz map one step per clock from a loaded
// start value, tracking orbit length, the peak of the iterate's upper bits,
// and a status code for zero input, overflow of 3n+1, and counter saturation.
module collatz_engine #(
    parameter int BITS      = 32,
    parameter int OLEN_BITS = 16,
    parameter int PLEN_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [BITS-1:0]      start_value,
    output logic                 busy,
    output logic                 done,
    output logic [BITS-1:0]      iter,
    output logic [OLEN_BITS-1:0] orbit_len,
    output logic [PLEN_BITS-1:0] path_record,
    output logic [1:0]           err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_ZERO = 2'b01;
    localparam logic [1:0] ERR_OVF  = 2'b10;
    localparam logic [1:0] ERR_SAT  = 2'b11;

    logic [1:0]           state_q, state_d;
    logic [BITS-1:0]      iter_q, iter_d;
    logic [OLEN_BITS-1:0] olen_q, olen_d;
    logic [PLEN_BITS-1:0] prec_q, prec_d;
    logic [1:0]           err_q, err_d;

    // Step datapath: 3n+1 is formed two bits wider so overflow is visible.
    logic                 odd;
    logic [BITS+1:0]      iter_ext;
    logic [BITS+1:0]      triple;
    logic                 ovf;
    logic [BITS-1:0]      next_iter;
    logic [PLEN_BITS-1:0] next_msb;
    logic [OLEN_BITS-1:0] olen_inc;

    // Candidate next iterate and its side information for the current step.
    always_comb begin
        odd       = iter_q[0];
        iter_ext  = {2'b00, iter_q};
        triple    = (iter_ext << 1) + iter_ext + (BITS+2)'(1);
        ovf       = odd && (triple[BITS+1:BITS] != 2'b00);
        next_iter = odd ? triple[BITS-1:0] : {1'b0, iter_q[BITS-1:1]};
        next_msb  = next_iter[BITS-1 -: PLEN_BITS];
        olen_inc  = olen_q + OLEN_BITS'(1);
    end

    // Next-state logic: start acceptance in IDLE/DONE, one step per RUN cycle.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        olen_d  = olen_q;
        prec_d  = prec_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    iter_d = start_value;
                    olen_d = '0;
                    prec_d = start_value[BITS-1 -: PLEN_BITS];
                    err_d  = ERR_OK;
                    if (start_value == '0) begin
                        state_d = DONE;
                        err_d   = ERR_ZERO;
                    end else if (start_value == BITS'(1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                olen_d = olen_inc;
                if (ovf) begin
                    // The iterate is left as-is so the failing value is visible.
                    state_d = DONE;
                    err_d   = ERR_OVF;
                end else begin
                    iter_d = next_iter;
                    if (next_msb > prec_q) begin
                        prec_d = next_msb;
                    end
                    if (next_iter == BITS'(1)) begin
                        state_d = DONE;
                        err_d   = ERR_OK;
                    end else if (olen_inc == '1) begin
                        state_d = DONE;
                        err_d   = ERR_SAT;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            iter_q  <= '0;
            olen_q  <= '0;
            prec_q  <= '0;
            err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            olen_q  <= olen_d;
            prec_q  <= prec_d;
            err_q   <= err_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign iter        = iter_q;
    assign orbit_len   = olen_q;
    assign path_record = prec_q;
    assign err         = err_q;

endmodule

// File: tb/tb_collatz_engine.sv
// tb_collatz_engine: directed vectors for the Collatz engine with hand-computed
// orbit results, plus sequences for start-in-RUN, async reset and saturation.
module tb_collatz_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] start_value;
    logic        busy, done;
    logic [15:0] iter;
    logic [15:0] orbit_len;
    logic [15:0] path_record;
    logic [1:0]  err;

    logic        s_start;
    logic [15:0] s_value;
    logic        s_busy, s_done;
    logic [15:0] s_iter;
    logic [3:0]  s_len;
    logic [15:0] s_prec;
    logic [1:0]  s_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    collatz_engine #(.BITS(16), .OLEN_BITS(16), .PLEN_BITS(16)) u_dut (
        .clk(clk), .reset(reset), .start(start), .start_value(start_value),
        .busy(busy), .done(done), .iter(iter), .orbit_len(orbit_len),
        .path_record(path_record), .err(err)
    );

    collatz_engine #(.BITS(16), .OLEN_BITS(4), .PLEN_BITS(16)) u_sat (
        .clk(clk), .reset(reset), .start(s_start), .start_value(s_value),
        .busy(s_busy), .done(s_done), .iter(s_iter), .orbit_len(s_len),
        .path_record(s_prec), .err(s_err)
    );

    typedef struct {
        logic [15:0] sv;
        int          len;
        logic [15:0] prec;
        logic [1:0]  err;
        logic [15:0] fin;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Pulse start for one edge, then count cycles until done (bounded).
    task automatic run_orbit(input logic [15:0] v, output int cycles, output bit busy_seen);
        start_value = v;
        start       = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
        cycles      = 0;
        busy_seen   = busy;
        while (!done && cycles < 3000) begin
            @(posedge clk); #1;
            cycles++;
            if (busy) busy_seen = 1'b1;
        end
        if (!done) cycles = -1;
    endtask

    initial begin
        int  cyc;
        bit  bseen;
        logic [15:0] hold_len;

        vecs[0]  = '{16'd1,      0, 16'd1,      2'b00, 16'd1};
        vecs[1]  = '{16'd0,      0, 16'd0,      2'b01, 16'd0};
        vecs[2]  = '{16'd2,      1, 16'd2,      2'b00, 16'd1};
        vecs[3]  = '{16'd3,      7, 16'd16,     2'b00, 16'd1};
        vecs[4]  = '{16'd6,      8, 16'd16,     2'b00, 16'd1};
        vecs[5]  = '{16'd7,     16, 16'd52,     2'b00, 16'd1};
        vecs[6]  = '{16'd16,     4, 16'd16,     2'b00, 16'd1};
        vecs[7]  = '{16'd27,   111, 16'h2410,   2'b00, 16'd1};
        vecs[8]  = '{16'hFFFF,   1, 16'hFFFF,   2'b10, 16'hFFFF};
        vecs[9]  = '{16'hFFFE,   2, 16'hFFFE,   2'b10, 16'h7FFF};
        vecs[10] = '{16'h5555,   1, 16'h5555,   2'b10, 16'h5555};
        vecs[11] = '{16'h5554,  17, 16'h5554,   2'b00, 16'd1};

        reset = 1'b1; start = 1'b0; start_value = '0;
        s_start = 1'b0; s_value = '0;
        @(posedge clk); #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_iter", iter, 0);
        check("reset_len",  orbit_len, 0);
        check("reset_prec", path_record, 0);
        check("reset_err",  err, 0);

        // Start while in reset must be ignored.
        start = 1'b1; start_value = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        check("start_in_reset_busy", busy, 0);
        check("start_in_reset_done", done, 0);
        check("start_in_reset_iter", iter, 0);

        for (int i = 0; i < 12; i++) begin
            run_orbit(vecs[i].sv, cyc, bseen);
            check($sformatf("v%0d_latency", vecs[i].sv), cyc, vecs[i].len);
            check($sformatf("v%0d_done", vecs[i].sv), done, 1);
            check($sformatf("v%0d_len", vecs[i].sv), orbit_len, vecs[i].len);
            check($sformatf("v%0d_prec", vecs[i].sv), path_record, vecs[i].prec);
            check($sformatf("v%0d_err", vecs[i].sv), err, vecs[i].err);
            check($sformatf("v%0d_iter", vecs[i].sv), iter, vecs[i].fin);
            check($sformatf("v%0d_busy_seen", vecs[i].sv), bseen, (vecs[i].len > 0));
        end

        // Results stay stable in DONE without a start.
        hold_len = orbit_len;
        repeat (3) @(posedge clk);
        #1;
        check("done_hold_done", done, 1);
        check("done_hold_len", orbit_len, hold_len);
        check("done_hold_iter", iter, 16'd1);

        // A start pulsed during RUN must not disturb the orbit of 27.
        start_value = 16'd27; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_run_busy", busy, 1);
        start_value = 16'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("ign_start_done", done, 1);
        check("ign_start_len", orbit_len, 111);
        check("ign_start_prec", path_record, 16'h2410);
        check("ign_start_err", err, 0);

        // Asynchronous reset mid-RUN clears outputs before any clock edge.
        start_value = 16'd27; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_iter", iter, 0);
        check("async_rst_len",  orbit_len, 0);
        check("async_rst_prec", path_record, 0);
        check("async_rst_err",  err, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_idle", {busy, done}, 2'b00);
        run_orbit(16'd6, cyc, bseen);
        check("post_rst_6_len", orbit_len, 8);
        check("post_rst_6_prec", path_record, 16);
        check("post_rst_6_err", err, 0);

        // Narrow orbit counter saturates on 27 after 15 steps.
        s_value = 16'd27; s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        cyc = 0;
        while (!s_done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("sat_latency", cyc, 15);
        check("sat_done", s_done, 1);
        check("sat_err", s_err, 2'b11);
        check("sat_len", s_len, 15);
        check("sat_iter", s_iter, 242);
        check("sat_prec", s_prec, 484);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/collatz_engine.md
COLLATZ_ENGINE -- requirements
Module: collatz_engine

Interface
REQ-001 SHALL have parameter BITS, default 32: width of the Collatz iterate register (minimum 16).
REQ-002 SHALL have parameter OLEN_BITS, default 16: width of the orbit-length counter.
REQ-003 SHALL have parameter PLEN_BITS, default 16: number of iterate MSBs tracked as the path record (PLEN_BITS <= BITS).
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: request to begin a new orbit from start_value.
REQ-007 SHALL have port start_value, input, BITS: starting iterate, sampled on an accepted start.
REQ-008 SHALL have port busy, output, 1: high while an orbit is being computed.
REQ-009 SHALL have port done, output, 1: high while results are valid.
REQ-010 SHALL have port iter, output, BITS: current iterate register.
REQ-011 SHALL have port orbit_len, output, OLEN_BITS: number of steps taken.
REQ-012 SHALL have port path_record, output, PLEN_BITS: maximum of iter[BITS-1 -: PLEN_BITS] seen in the orbit.
REQ-013 SHALL have port err, output, 2: result status; 00 ok, 01 zero input, 10 iterate overflow, 11 orbit_len saturated.

Function
REQ-014 SHALL implement the states IDLE, RUN and DONE; busy=1 only in RUN; done=1 only in DONE.
REQ-015 SHALL accept start only in IDLE or DONE; start in RUN is ignored with no effect.
REQ-016 On an accepted start (edge t), SHALL at t: load iter=start_value, orbit_len=0, path_record=start_value[BITS-1 -: PLEN_BITS], err=00.
REQ-017 On an accepted start, SHALL go to RUN if start_value>1, to DONE with err=00 if start_value==1, and to DONE with err=01 if start_value==0.
REQ-018 Each RUN cycle SHALL perform exactly one step: even iter -> iter>>1; odd iter -> 3*iter+1, computed at BITS+2 width.
REQ-019 Each RUN step SHALL increment orbit_len by 1.
REQ-020 Each RUN step SHALL set path_record=max(path_record, next[BITS-1 -: PLEN_BITS]).
REQ-021 If the next iterate equals 1, SHALL commit that step and go to DONE on the same edge with err=00.
REQ-022 If 3*iter+1 does not fit in BITS bits, SHALL leave iter unchanged, still increment orbit_len, and go to DONE with err=10.
REQ-023 If orbit_len reaches all-ones without reaching 1, SHALL go to DONE with err=11 and iter holding the last value.
REQ-024 Overflow SHALL take priority over saturation when both occur in the same step.
REQ-025 In DONE, SHALL hold iter, orbit_len, path_record and err stable until the next accepted start.
REQ-026 Latency SHALL be N+1 cycles from the start edge to done=1, for a start value whose orbit has N steps.
REQ-027 SHALL never pass from IDLE to RUN, or from DONE to RUN, without an accepted start.

Reset
REQ-028 While reset=1, and asynchronously on its assertion, SHALL force: state=IDLE, busy=0, done=0, iter=0, orbit_len=0, path_record=0, err=00.
REQ-029 Reset asserted mid-RUN SHALL abort the orbit with no residual state; the first start after reset behaves as a fresh start.
REQ-030 SHALL ignore start while reset=1.

Verification
REQ-031 BITS=16, start_value=3: after 7 RUN cycles -> done=1, iter=1, orbit_len=7, path_record=16, err=00.
REQ-032 BITS=16, start_value=27: -> orbit_len=111, path_record=0x2410 (9232), err=00.
REQ-033 start_value=1 -> done=1 after 1 cycle, orbit_len=0, err=00; start_value=0 -> done=1, err=01, busy never asserts.
REQ-034 BITS=16, start_value=0xFFFF -> done after 1 RUN cycle, err=10, iter=0xFFFF, orbit_len=1.
REQ-035 start=1 pulsed during RUN -> no change to the ongoing orbit; reset pulsed mid-RUN -> all outputs 0 immediately (asynchronously), then a new start of 6 gives orbit_len=8.
REQ-036 OLEN_BITS=4, start_value=27 -> err=11, orbit_len=15, done=1.
